// File: rtl/stim_sequencer.sv
// stim_sequencer: plays stored vectors on stim and folds dut_y into a signature (STIM_SEQUENCER_MISR_EN selects MISR folding)
module stim_sequencer #(
  parameter int DEPTH = 32,
  parameter int HOLD = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [68:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   num_vec,
  output logic [68:0]   stim,
  input  logic [98:0]   dut_y,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] vec_idx,
  output logic [98:0]   signature
);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t state;
  logic [68:0] mem [DEPTH];
  logic [AW:0] count;
  logic [AW:0] clamp;
  logic [3:0] hold;
  logic [68:0] first;
  logic [98:0] fold;
  logic last;
  logic hold_end;
  // run parameters, the first vector with same-cycle write bypass, and the signature update
  always_comb begin
    clamp = num_vec > DEPTH_W ? DEPTH_W : num_vec;
    first = (wr_en && wr_addr == '0) ? wr_data : mem[0];
    last = ({1'b0, vec_idx} + 1'b1) >= count;
    hold_end = hold == HOLD_LAST;
`ifdef STIM_SEQUENCER_MISR_EN
    fold = ({signature[97:0], 1'b0} ^ (signature[98] ? 99'h49 : 99'h0)) ^ dut_y;
`else
    fold = dut_y;
`endif
  end
  // vector store writes are blocked while a run is applying vectors
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end
  // sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      vec_idx <= '0;
      signature <= '0;
      hold <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          signature <= '0;
          hold <= '0;
          vec_idx <= '0;
          count <= clamp;
          if (num_vec != '0) begin
            state <= APPLY;
            busy <= 1'b1;
            stim <= first;
          end else begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        APPLY: if (hold_end) begin
          signature <= fold;
          hold <= '0;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            stim <= '0;
          end else begin
            vec_idx <= vec_idx + 1'b1;
            stim <= mem[vec_idx + 1'b1];
          end
        end else begin
          hold <= hold + 4'd1;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
